// File: rtl/camera_bus_pkg.sv
// Shared camera-bus definitions: default frame timing, FSM state encoding
// and colour field widths used by the stream generator and colour expander.
package camera_bus_pkg;

    localparam int DEF_H_ACTIVE  = 176;
    localparam int DEF_V_ACTIVE  = 144;
    localparam int DEF_H_BLANK   = 16;
    localparam int DEF_VSYNC_LEN = 8;
    localparam int DEF_V_BACK    = 8;
    localparam int DEF_V_FRONT   = 8;

    localparam int ADDR_W   = 15;
    localparam int CNT_W    = 16;
    localparam int RGB332_W = 8;
    localparam int RGB565_W = 16;
    localparam int R3_W     = 3;
    localparam int G3_W     = 3;
    localparam int B2_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        VS,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } cam_state_t;

endpackage

// File: rtl/rgb332_to_rgb565.sv
// Combinational RGB332 -> RGB565 expansion by replicating the MSBs of each
// field into the new low bits, so full-scale stays full-scale.
module rgb332_to_rgb565
    import camera_bus_pkg::*;
(
    input  logic [RGB332_W-1:0] pix332,
    output logic [RGB565_W-1:0] pix565
);

    logic [R3_W-1:0] r3;
    logic [G3_W-1:0] g3;
    logic [B2_W-1:0] b2;

    assign {r3, g3, b2} = pix332;
    assign pix565 = {r3, r3[2:1], g3, g3, b2, b2, b2[1]};

endmodule

// File: rtl/camera_stream_gen.sv
// Frame-buffer to camera-bus streamer: VSYNC/HREF timing FSM, read-address
// prefetch two cycles ahead of each pixel, and RGB565 byte serialisation.
module camera_stream_gen
    import camera_bus_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_FRONT   = DEF_V_FRONT
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                EN,
    input  logic [7:0]          rd_data,
    output logic [ADDR_W-1:0]   X_ADDR,
    output logic [ADDR_W-1:0]   Y_ADDR,
    output logic                HREF,
    output logic                VSYNC,
    output logic [7:0]          output_data,
    output logic                frame_done
);

    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VSYNC_LEN - 1);
    localparam logic [CNT_W-1:0]  VB_LAST   = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0]  ACT_LAST  = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  VF_LAST   = CNT_W'(V_FRONT - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] X_FIRST_NEXT = ADDR_W'((H_ACTIVE > 1) ? 1 : 0);

    cam_state_t state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [ADDR_W-1:0]   line, line_d;
    logic [RGB332_W-1:0] pix;
    logic [RGB332_W-1:0] exp_in;
    logic [RGB565_W-1:0] exp_out;
    logic                pre_line, last_blank;
    logic [ADDR_W-1:0]   pre_y, nx;

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        line_d  = line;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (EN) state_d = VS;
            end
            VS: if (cnt == VS_LAST) begin
                state_d = VBACK;
                cnt_d   = '0;
            end
            VBACK: if (cnt == VB_LAST) begin
                state_d = ACTIVE;
                cnt_d   = '0;
                line_d  = '0;
            end
            ACTIVE: if (cnt == ACT_LAST) begin
                state_d = HBLANK;
                cnt_d   = '0;
            end
            HBLANK: if (cnt == HB_LAST) begin
                cnt_d = '0;
                if (line < LINE_LAST) begin
                    state_d = ACTIVE;
                    line_d  = line + ADDR_W'(1);
                end else begin
                    state_d = VFRONT;
                end
            end
            VFRONT: if (cnt == VF_LAST) begin
                cnt_d   = '0;
                state_d = EN ? VS : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decisions are made on next-cycle state so addresses land exactly two
    // cycles ahead of the high-byte cycle of each pixel.
    always_comb begin
        pre_line   = (state_d == VBACK && cnt_d == VB_LAST - CNT_W'(1)) ||
                     (state_d == HBLANK && cnt_d == HB_LAST - CNT_W'(1) && line_d < LINE_LAST);
        last_blank = (state_d == VBACK && cnt_d == VB_LAST) ||
                     (state_d == HBLANK && cnt_d == HB_LAST && line_d < LINE_LAST);
        pre_y      = (state_d == VBACK) ? '0 : line_d + ADDR_W'(1);
        nx         = cnt_d[CNT_W-1:1] + ADDR_W'(1);
        exp_in     = cnt_d[0] ? pix : rd_data;
    end

    rgb332_to_rgb565 u_exp (
        .pix332 (exp_in),
        .pix565 (exp_out)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cnt         <= '0;
            line        <= '0;
            pix         <= '0;
            X_ADDR      <= '0;
            Y_ADDR      <= '0;
            HREF        <= 1'b0;
            VSYNC       <= 1'b0;
            output_data <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            line       <= line_d;
            HREF       <= (state_d == ACTIVE);
            VSYNC      <= (state_d == VS);
            frame_done <= (state_d == VFRONT) && (cnt_d == VF_LAST);

            // Even cycle: latch the fresh read and send its high byte;
            // odd cycle: low byte of the same latched pixel.
            if (state_d == ACTIVE) begin
                if (!cnt_d[0]) begin
                    pix         <= rd_data;
                    output_data <= exp_out[15:8];
                end else begin
                    output_data <= exp_out[7:0];
                end
            end else begin
                output_data <= '0;
            end

            if (state_d == IDLE) begin
                X_ADDR <= '0;
                Y_ADDR <= '0;
            end else if (pre_line) begin
                X_ADDR <= '0;
                Y_ADDR <= pre_y;
            end else if (last_blank) begin
                X_ADDR <= X_FIRST_NEXT;
            end else if (state_d == ACTIVE && !cnt_d[0] && nx <= X_LAST) begin
                X_ADDR <= nx;
            end
        end
    end

endmodule
